// File: rtl/ccastles_vram_pkg.sv
// ccastles_vram_pkg: shared tags, clear states and latencies for the VRAM arbiter
package ccastles_vram_pkg;
   typedef enum logic [2:0] {NONE, VID, CPU_RD, CPU_WR, CLR} tag_t;
   typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;
   localparam int VID_LAT    = 3;
   localparam int CPU_RD_LAT = 3;
   localparam int CPU_WR_LAT = 2;
endpackage

// File: rtl/ccastles_vram_clear.sv
// ccastles_vram_clear: walks every VRAM address once, advancing only on granted slots
module ccastles_vram_clear
   import ccastles_vram_pkg::*;
#(
   parameter int ADDR_W = 15
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic              grant_i,
   output logic              busy_o,
   output logic              req_o,
   output logic [ADDR_W-1:0] addr_o
);
   clr_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= CLR_IDLE;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end
   always_comb begin
      state_d = (state_q == CLR_IDLE) ? (start_i ? CLR_RUN : CLR_IDLE)
              : (grant_i && &addr_q) ? CLR_IDLE : CLR_RUN;
      addr_d  = (state_q == CLR_IDLE) ? '0 : grant_i ? addr_q + 1'b1 : addr_q;
   end
   assign busy_o = state_q == CLR_RUN;
   assign req_o  = busy_o;
   assign addr_o = addr_q;
endmodule

// File: rtl/ccastles_vram_arbiter.sv
// ccastles_vram_arbiter: shares one VRAM port between scanout, clear sequencer and CPU
module ccastles_vram_arbiter
   import ccastles_vram_pkg::*;
#(
   parameter int                ADDR_W   = 15,
   parameter int                DATA_W   = 8,
   parameter int                MAX_WAIT = 8,
   parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              vid_req_i,
   input  logic [ADDR_W-1:0] vid_addr_i,
   output logic [DATA_W-1:0] vid_data_o,
   output logic              vid_valid_o,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_din_i,
   input  logic [1:0]        cpu_nib_i,
   output logic              cpu_ack_o,
   output logic [DATA_W-1:0] cpu_dout_o,
   input  logic              clr_start_i,
   output logic              clr_busy_o,
   output logic              starve_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_we_o,
   output logic [1:0]        ram_be_o,
   output logic [DATA_W-1:0] ram_din_o,
   input  logic [DATA_W-1:0] ram_dout_i
);
   localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);
   localparam int                DEPTH    = VID_LAT - 1;
   localparam int                VID_STG  = VID_LAT - 2;
   localparam int                RD_STG   = CPU_RD_LAT - 2;
   localparam int                WR_STG   = CPU_WR_LAT - 2;
   tag_t              tag_q [DEPTH];
   tag_t              tag_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d, clr_addr;
   logic [DATA_W-1:0] ram_din_q, ram_din_d, vid_data_q, vid_data_d, cpu_dout_q, cpu_dout_d;
   logic [1:0]        ram_be_q, ram_be_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              ram_we_q, ram_we_d, vid_valid_q, vid_valid_d, cpu_ack_q, cpu_ack_d;
   logic              inflight_q, inflight_d, starve_q, starve_d;
   logic              clr_req, clr_win, cpu_win, cpu_wr_win;
   ccastles_vram_clear #(.ADDR_W(ADDR_W)) u_clear (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .start_i (clr_start_i),
      .grant_i (clr_win),
      .busy_o  (clr_busy_o),
      .req_o   (clr_req),
      .addr_o  (clr_addr)
   );
   // a clr_start arriving while idle already outranks the CPU in that same cycle
   assign clr_win    = clr_req & ~vid_req_i;
   assign cpu_win    = cpu_req_i & ~inflight_q & ~vid_req_i & ~clr_req & ~clr_start_i;
   assign cpu_wr_win = cpu_win & cpu_we_i;
   always_comb begin
      tag_d       = vid_req_i ? VID : clr_win ? CLR : cpu_win ? (cpu_we_i ? CPU_WR : CPU_RD) : NONE;
      ram_addr_d  = vid_req_i ? vid_addr_i : clr_win ? clr_addr : cpu_win ? cpu_addr_i : ram_addr_q;
      ram_we_d    = clr_win | cpu_wr_win;
      ram_be_d    = clr_win ? 2'b11 : cpu_wr_win ? cpu_nib_i : 2'b00;
      ram_din_d   = clr_win ? CLR_VAL : cpu_wr_win ? cpu_din_i : ram_din_q;
      vid_valid_d = tag_q[VID_STG] == VID;
      vid_data_d  = vid_valid_d ? ram_dout_i : vid_data_q;
      cpu_ack_d   = (tag_q[WR_STG] == CPU_WR) || (tag_q[RD_STG] == CPU_RD);
      cpu_dout_d  = (tag_q[RD_STG] == CPU_RD) ? ram_dout_i : cpu_dout_q;
      inflight_d  = cpu_win | (inflight_q & ~cpu_ack_q);
      wait_d      = (!cpu_req_i || cpu_win) ? '0
                  : (!inflight_q && wait_q != WAIT_SAT) ? wait_q + 1'b1 : wait_q;
      starve_d    = starve_q | (wait_d == WAIT_SAT);
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int j = 0; j < DEPTH; j++) tag_q[j] <= NONE;
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_be_q    <= '0;
         ram_din_q   <= '0;
         vid_valid_q <= 1'b0;
         vid_data_q  <= '0;
         cpu_ack_q   <= 1'b0;
         cpu_dout_q  <= '0;
         inflight_q  <= 1'b0;
         wait_q      <= '0;
         starve_q    <= 1'b0;
      end else begin
         tag_q[0] <= tag_d;
         for (int j = 1; j < DEPTH; j++) tag_q[j] <= tag_q[j-1];
         ram_addr_q  <= ram_addr_d;
         ram_we_q    <= ram_we_d;
         ram_be_q    <= ram_be_d;
         ram_din_q   <= ram_din_d;
         vid_valid_q <= vid_valid_d;
         vid_data_q  <= vid_data_d;
         cpu_ack_q   <= cpu_ack_d;
         cpu_dout_q  <= cpu_dout_d;
         inflight_q  <= inflight_d;
         wait_q      <= wait_d;
         starve_q    <= starve_d;
      end
   end
   assign ram_addr_o  = ram_addr_q;
   assign ram_we_o    = ram_we_q;
   assign ram_be_o    = ram_be_q;
   assign ram_din_o   = ram_din_q;
   assign vid_valid_o = vid_valid_q;
   assign vid_data_o  = vid_data_q;
   assign cpu_ack_o   = cpu_ack_q;
   assign cpu_dout_o  = cpu_dout_q;
   assign starve_o    = starve_q;
endmodule

// File: tb/tb_ccastles_vram_arbiter.sv
// tb_ccastles_vram_arbiter: scoreboard bench with a behavioural VRAM model
module tb_ccastles_vram_arbiter;
   import ccastles_vram_pkg::*;
   logic        clk = 1'b0, reset = 1'b1;
   logic        vid_req = 1'b0, vid_valid;
   logic [14:0] vid_addr = '0, cpu_addr = '0, ram_addr;
   logic [7:0]  vid_data, cpu_din = '0, cpu_dout, ram_din, ram_dout;
   logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_ack, clr_start = 1'b0, clr_busy, starve, ram_we;
   logic [1:0]  cpu_nib = '0, ram_be;
   int          cyc = 0, errors = 0, checks = 0;
   typedef struct { logic [7:0] data; logic chk; int cyc; } exp_t;
   exp_t        vid_q[$], cpu_q[$];
   logic [7:0]  mem [0:32767];
   logic        pre_en = 1'b0, pre_rand = 1'b0;
   logic [14:0] pre_addr = '0;
   logic [7:0]  pre_data = '0;

   ccastles_vram_arbiter dut (
      .clk_i(clk), .reset_i(reset),
      .vid_req_i(vid_req), .vid_addr_i(vid_addr), .vid_data_o(vid_data), .vid_valid_o(vid_valid),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_din_i(cpu_din),
      .cpu_nib_i(cpu_nib), .cpu_ack_o(cpu_ack), .cpu_dout_o(cpu_dout),
      .clr_start_i(clr_start), .clr_busy_o(clr_busy), .starve_o(starve),
      .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_din_o(ram_din),
      .ram_dout_i(ram_dout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (pre_rand) for (int i = 0; i < 32768; i++) mem[i] <= 8'($urandom);
      else if (pre_en) mem[pre_addr] <= pre_data;
      else if (ram_we) begin
         if (ram_be[1]) mem[ram_addr][7:4] <= ram_din[7:4];
         if (ram_be[0]) mem[ram_addr][3:0] <= ram_din[3:0];
      end
      ram_dout <= mem[ram_addr];
   end

   always @(negedge clk) begin
      exp_t e;
      if (!reset && vid_valid) begin
         checks++;
         if (vid_q.size() == 0) begin
            errors++;
            $display("FAIL vid_unexpected: got valid at cyc=%0d data=%h, required none", cyc, vid_data);
         end else begin
            e = vid_q.pop_front();
            if (cyc != e.cyc || (e.chk && vid_data !== e.data)) begin
               errors++;
               $display("FAIL vid_fetch: got data=%h cyc=%0d, required data=%h cyc=%0d", vid_data, cyc, e.data, e.cyc);
            end
         end
      end
      if (!reset && cpu_ack) begin
         checks++;
         if (cpu_q.size() == 0) begin
            errors++;
            $display("FAIL cpu_unexpected: got ack at cyc=%0d, required none", cyc);
         end else begin
            e = cpu_q.pop_front();
            if ((e.cyc >= 0 && cyc != e.cyc) || (e.chk && cpu_dout !== e.data) || clr_busy !== 1'b0) begin
               errors++;
               $display("FAIL cpu_ack: got dout=%h cyc=%0d busy=%b, required dout=%h cyc=%0d busy=0", cpu_dout, cyc, clr_busy, e.data, e.cyc);
            end
         end
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_cycle(input int n);
      while (cyc < n) step();
   endtask

   task automatic preload(input logic [14:0] a, input logic [7:0] d);
      pre_en = 1'b1; pre_addr = a; pre_data = d;
      step();
      pre_en = 1'b0;
   endtask

   task automatic check_outputs_zero(input string name);
      @(negedge clk);
      checks++;
      if ({vid_data, vid_valid, cpu_ack, cpu_dout, clr_busy, starve, ram_addr, ram_we, ram_be, ram_din} !== '0) begin
         errors++;
         $display("FAIL %s: got vd=%h vv=%b ack=%b dout=%h busy=%b starve=%b ra=%h we=%b be=%b din=%h, required all 0",
                  name, vid_data, vid_valid, cpu_ack, cpu_dout, clr_busy, starve, ram_addr, ram_we, ram_be, ram_din);
      end
   endtask

   task automatic wait_ack(input int bound, input string name);
      bit got = 0;
      for (int k = 0; k < bound && !got; k++) begin
         @(negedge clk);
         got = cpu_ack;
      end
      cpu_req = 1'b0;
      if (!got) begin
         checks++; errors++;
         $display("FAIL %s: got no ack within %0d cycles, required ack", name, bound);
      end
   endtask

   task automatic cpu_op(input logic we, input logic [14:0] a, input logic [7:0] d, input logic [1:0] nib,
                         input logic [7:0] exp, input int lat, input string name);
      step();
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d; cpu_nib = nib;
      cpu_q.push_back('{data: exp, chk: !we, cyc: cyc + lat});
      wait_ack(20, name);
   endtask

   task automatic test_reset();
      repeat (3) step();
      check_outputs_zero("reset_state");
      step();
      reset = 1'b0;
      preload(15'h0100, 8'hA1);
      preload(15'h0101, 8'hA2);
      preload(15'h0102, 8'hA3);
      preload(15'h7FFF, 8'h5C);
      preload(15'h0040, 8'hFF);
   endtask

   task automatic test_video_latency();
      logic [7:0] vexp [3] = '{8'hA1, 8'hA2, 8'hA3};
      for (int i = 0; i < 3; i++) begin
         at_cycle(10 + 2 * i);
         vid_req = 1'b1; vid_addr = 15'h0100 + 15'(i);
         vid_q.push_back('{data: vexp[i], chk: 1'b1, cyc: cyc + VID_LAT});
         step();
         vid_req = 1'b0;
      end
      at_cycle(19);
   endtask

   task automatic test_conflict();
      at_cycle(20);
      vid_req = 1'b1; vid_addr = 15'h0100;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h7FFF;
      vid_q.push_back('{data: 8'hA1, chk: 1'b1, cyc: cyc + VID_LAT});
      cpu_q.push_back('{data: 8'h5C, chk: 1'b1, cyc: cyc + 4});
      step();
      vid_req = 1'b0;
      @(negedge clk);
      checks++;
      if (ram_addr !== 15'h0100 || ram_we !== 1'b0) begin
         errors++;
         $display("FAIL conflict_vid_issue: got addr=%h we=%b, required addr=0100 we=0", ram_addr, ram_we);
      end
      step();
      @(negedge clk);
      checks++;
      if (ram_addr !== 15'h7FFF || ram_we !== 1'b0) begin
         errors++;
         $display("FAIL conflict_cpu_issue: got addr=%h we=%b, required addr=7fff we=0", ram_addr, ram_we);
      end
      wait_ack(10, "conflict_ack");
   endtask

   task automatic test_back_to_back_nibble();
      cpu_op(1'b1, 15'h0040, 8'h12, 2'b01, 8'h00, CPU_WR_LAT, "nib_wr_lo");
      cpu_op(1'b0, 15'h0040, 8'h00, 2'b00, 8'hF2, CPU_RD_LAT, "nib_rd_lo");
      cpu_op(1'b1, 15'h0040, 8'h34, 2'b10, 8'h00, CPU_WR_LAT, "nib_wr_hi");
      cpu_op(1'b0, 15'h0040, 8'h00, 2'b00, 8'h32, CPU_RD_LAT, "nib_rd_hi");
      cpu_op(1'b1, 15'h0040, 8'h99, 2'b00, 8'h00, CPU_WR_LAT, "nib_wr_none");
      cpu_op(1'b0, 15'h0040, 8'h00, 2'b00, 8'h32, CPU_RD_LAT, "nib_rd_none");
   endtask

   task automatic test_starvation();
      step();
      vid_req = 1'b1; vid_addr = 15'h0100;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0101;
      cpu_q.push_back('{data: 8'hA2, chk: 1'b1, cyc: cyc + 12 + CPU_RD_LAT});
      for (int k = 0; k < 12; k++) begin
         vid_q.push_back('{data: 8'hA1, chk: 1'b1, cyc: cyc + VID_LAT});
         @(negedge clk);
         if (k == 7) begin
            checks++;
            if (starve !== 1'b0) begin errors++; $display("FAIL starve_early: got %b after 7 waits, required 0", starve); end
         end
         if (k == 8) begin
            checks++;
            if (starve !== 1'b1) begin errors++; $display("FAIL starve_set: got %b after 8 waits, required 1", starve); end
         end
         step();
      end
      vid_req = 1'b0;
      wait_ack(10, "starve_cpu_ack");
      repeat (5) step();
      @(negedge clk);
      checks++;
      if (starve !== 1'b1) begin errors++; $display("FAIL starve_sticky: got %b, required 1", starve); end
   endtask

   task automatic test_reset_mid_read();
      step();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0102;
      step();
      step();
      reset = 1'b1; cpu_req = 1'b0;
      step();
      reset = 1'b0;
      check_outputs_zero("reset_mid_read");
      repeat (6) step();
      cpu_op(1'b0, 15'h0102, 8'h00, 2'b00, 8'hA3, CPU_RD_LAT, "after_reset_rd");
   endtask

   task automatic test_clear();
      int n = 0, nz = 0;
      bit done = 0;
      step();
      pre_rand = 1'b1;
      step();
      pre_rand = 1'b0;
      clr_start = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0200;
      cpu_q.push_back('{data: 8'h00, chk: 1'b1, cyc: -1});
      step();
      clr_start = 1'b0;
      for (int k = 0; k < 70000 && !done; k++) begin
         vid_req = (k % 2) == 0;
         clr_start = (k == 100);
         vid_addr = 15'(k);
         if (vid_req) vid_q.push_back('{data: 8'h00, chk: 1'b0, cyc: cyc + VID_LAT});
         @(negedge clk);
         if (ram_we) n++;
         if (!clr_busy) done = 1;
         step();
      end
      vid_req = 1'b0; clr_start = 1'b0;
      checks++;
      if (!done || n != 32768) begin
         errors++;
         $display("FAIL clear_writes: got %0d writes (finished=%0d), required 32768", n, done);
      end
      wait_ack(20, "clear_cpu_ack");
      @(negedge clk);
      checks++;
      if (starve !== 1'b1) begin errors++; $display("FAIL clear_starve: got %b, required 1", starve); end
      for (int i = 0; i < 32768; i++) if (mem[i] !== 8'h00) nz++;
      checks++;
      if (nz != 0) begin errors++; $display("FAIL clear_contents: got %0d nonzero bytes, required 0", nz); end
   endtask

   initial begin
      test_reset();
      test_video_latency();
      test_conflict();
      test_back_to_back_nibble();
      test_starvation();
      test_reset_mid_read();
      test_clear();
      repeat (6) step();
      checks++;
      if (vid_q.size() != 0 || cpu_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d vid and %0d cpu pending, required 0", vid_q.size(), cpu_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ccastles_vram_arbiter.md
Name: ccastles_vram_arbiter

Overview:
- Shares the single-port 32K x 8 bitmap video RAM between three requesters: video scanout fetch, the game CPU, and a bulk-clear sequencer.
- Scanout has strict priority and a fixed, guaranteed latency. The CPU uses a req/ack handshake and has nibble write enables for 4-bit pixel writes.
- Sits inside the ccastles core, between the 6502 bus decode / video counters and the VRAM instance, all on clk_game.

Parameters:
- ADDR_W, 15, VRAM address width (32768 bytes).
- DATA_W, 8, VRAM data width (two 4-bit pixels per byte).
- MAX_WAIT, 8, number of consecutive cycles a pending CPU request may wait before the starve flag sets.
- CLR_VAL, 8'h00, byte written by the clear sequencer.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-high.
- vid_req  in  1  one-cycle fetch strobe. Upstream guarantees a spacing of at least 2 cycles.
- vid_addr  in  ADDR_W  fetch address, sampled with vid_req.
- vid_data  out  DATA_W  fetched byte.
- vid_valid  out  1  one-cycle strobe qualifying vid_data.
- cpu_req  in  1  request, held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_din  in  DATA_W  write data.
- cpu_nib  in  2  nibble enables: [1] = bits 7:4, [0] = bits 3:0.
- cpu_ack  out  1  one-cycle completion strobe.
- cpu_dout  out  DATA_W  read data, valid with cpu_ack on reads.
- clr_start  in  1  one-cycle strobe that starts a full-RAM clear.
- clr_busy  out  1  high while a clear is running.
- starve  out  1  sticky, cleared only by reset.
- ram_addr  out  ADDR_W  VRAM address (registered).
- ram_we  out  1  VRAM write enable (registered).
- ram_be  out  2  VRAM nibble enables (registered).
- ram_din  out  DATA_W  VRAM write data (registered).
- ram_dout  in  DATA_W  VRAM read data, valid 1 cycle after ram_addr.

Behaviour:
- Reset values: all outputs 0, clear sequencer idle, pipeline tags empty, cpu_inflight = 0, wait counter = 0.
  - Reset mid-operation aborts any in-flight access: no ack and no valid is issued afterwards.
- Issue slot: one access per cycle. Priority is vid_req > clear > CPU.
  - Winner's address, data and enables are registered onto ram_* at t+1.
  - Cycles with no winner drive ram_we = 0 and ram_be = 0. ram_addr holds its last value.
- Pipeline tags track each issued access through stages I (t+1), R (t+2) and O (t+3). Tag values: NONE, VID, CPU_RD, CPU_WR, CLR.
- Video read:
  - vid_req at cycle t gives vid_valid = 1 and vid_data = ram_dout(t+2), registered, at t+3.
  - Latency is exactly 3 cycles and never depends on CPU or clear activity.
- CPU write:
  - Issues ram_we = 1 with ram_be = cpu_nib. A write with cpu_nib = 2'b00 still issues and acks but modifies nothing.
  - cpu_ack pulses at I+1.
- CPU read:
  - Issues ram_we = 0.
  - cpu_ack pulses and cpu_dout is registered at I+2.
- CPU handshake:
  - cpu_inflight sets on issue and clears on ack. While it is set, cpu_req is ignored, so there is no double issue.
  - A new request may be presented the cycle after ack and is issuable that cycle.
  - A cpu_req arriving in the same cycle as vid_req waits; it is issued in the next free cycle.
- Starvation guard:
  - The wait counter increments each cycle that cpu_req = 1, cpu_inflight = 0, and the CPU did not win.
  - It resets to 0 on CPU issue or when cpu_req drops.
  - Reaching MAX_WAIT sets starve. The counter saturates.
- Clear sequencer (states CLR_IDLE, CLR_RUN):
  - clr_start in CLR_IDLE enters CLR_RUN with address 0 and clr_busy = 1 the next cycle. clr_start while in CLR_RUN is ignored.
  - CLR_RUN writes CLR_VAL with ram_be = 2'b11 in every slot not taken by video.
  - The address increments per issued write. After writing 2^ADDR_W - 1 (wrap) it returns to CLR_IDLE, and clr_busy drops the cycle after that final issue.
  - CPU requests are held, never issued and never acked, while clr_busy = 1.
  - The wait counter keeps counting during a clear, so starve may set.
- Simultaneous clr_start and cpu_req in CLR_IDLE: clear wins, and the CPU waits for the entire clear.
- Width rules: the address counter is ADDR_W bits and wraps naturally. No arithmetic is applied to data.

Decomposition:
- Package ccastles_vram_pkg holds:
  - the tag enum (NONE, VID, CPU_RD, CPU_WR, CLR);
  - the clear state enum (CLR_IDLE, CLR_RUN);
  - the localparams VID_LAT = 3, CPU_RD_LAT = 3 and CPU_WR_LAT = 2, all counted from request.
- Sub-module ccastles_vram_clear holds the state machine and address walker.
  - Inputs: start, grant. Outputs: busy, req, addr.
  - The arbiter's top-level priority mux and the tag pipeline stay in ccastles_vram_arbiter.

Test Plan:
- Video latency: vid_req at cycles 10, 12 and 14 with addresses 0x0100, 0x0101 and 0x0102, RAM preloaded with 0xA1, 0xA2 and 0xA3 -> vid_valid at cycles 13, 15 and 17 with vid_data 0xA1, 0xA2 and 0xA3.
- Conflict: cpu_req read of 0x7FFF (holding 0x5C) in the same cycle as vid_req at cycle 20 -> video issued at 21, CPU issued at 22, cpu_ack with cpu_dout = 0x5C at 24, and vid_valid at 23.
- Nibble write: RAM[0x0040] = 0xFF, CPU write of 0x12 with cpu_nib = 2'b01 -> after ack, reading 0x0040 returns 0xF2. A second write of 0x34 with cpu_nib = 2'b10 -> read returns 0x32.
- Clear:
  - Setup: clr_start with RAM seeded at random, vid_req every 2 cycles, and cpu_req held throughout.
  - Expected: clr_busy stays high for exactly 32768 issued writes, and all bytes read back 0x00.
  - Expected: no cpu_ack until after clr_busy falls; then one ack for the held request.
  - Expected: starve = 1.
- Starvation (the stimulus intentionally violates the upstream 2-cycle vid_req spacing guarantee): vid_req every cycle for 12 cycles with cpu_req held -> starve sets after the 8th wait cycle and stays set after the traffic stops.
- Reset mid-read: CPU read issued, reset asserted at I+1 for 1 cycle -> no cpu_ack, all outputs 0. A fresh request after reset completes normally.
